// File: rtl/mult_ctrl_pkg.sv
// Shared types and default widths for the digit-serial multiplier sequencer.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    localparam int MC_A_WIDTH     = 64;
    localparam int MC_B_WIDTH     = 64;
    localparam int MC_DIGIT_WIDTH = 8;

    // Digit-counter width; a single-digit multiplier still needs one bit.
    function automatic int digit_cnt_width(input int b_width, input int digit_width);
        int n;
        n = b_width / digit_width;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_multiplier.sv
// Combinational unsigned X_WIDTH x Y_WIDTH multiplier array.
module param_multiplier #(
    parameter int X_WIDTH = 64,
    parameter int Y_WIDTH = 8
) (
    input  logic [X_WIDTH-1:0]         x,
    input  logic [Y_WIDTH-1:0]         y,
    output logic [X_WIDTH+Y_WIDTH-1:0] p
);

    logic [X_WIDTH+Y_WIDTH-1:0] x_ext;
    logic [X_WIDTH+Y_WIDTH-1:0] y_ext;

    assign x_ext = {{Y_WIDTH{1'b0}}, x};
    assign y_ext = {{X_WIDTH{1'b0}}, y};
    assign p     = x_ext * y_ext;

endmodule

// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial sequencer: multiplies a by b one DIGIT_WIDTH digit of b per cycle.
//   state | meaning
//   IDLE  | ready for an operand pair
//   RUN   | one digit of b multiplied and accumulated per cycle
//   DONE  | product presented, waiting for out_ready
module digit_serial_mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int A_WIDTH     = MC_A_WIDTH,
    parameter int B_WIDTH     = MC_B_WIDTH,
    parameter int DIGIT_WIDTH = MC_DIGIT_WIDTH,
    parameter bit EARLY_EXIT  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] prod,
    output logic                       busy
);

    localparam int N   = B_WIDTH / DIGIT_WIDTH;
    localparam int K_W = digit_cnt_width(B_WIDTH, DIGIT_WIDTH);
    localparam int P_W = A_WIDTH + B_WIDTH;
    localparam int PP_W = A_WIDTH + DIGIT_WIDTH;

    if (B_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_b_width
        $error("B_WIDTH must be a multiple of DIGIT_WIDTH");
    end
    if (DIGIT_WIDTH < 2) begin : g_bad_digit_width
        $error("DIGIT_WIDTH must be at least 2");
    end

    mult_state_e               state;
    logic [A_WIDTH-1:0]        a_q;
    logic [B_WIDTH-1:0]        b_q;
    logic [K_W-1:0]            k;
    logic [P_W-1:0]            acc;

    logic [DIGIT_WIDTH-1:0]    cur_digit;
    logic [PP_W-1:0]           pp;
    logic [P_W-1:0]            pp_ext;
    logic [31:0]               shamt;
    logic [P_W-1:0]            acc_next;
    logic                      upper_nz;
    logic                      last_digit;
    logic                      run_exit;

    assign cur_digit = b_q[32'(k) * DIGIT_WIDTH +: DIGIT_WIDTH];

    param_multiplier #(
        .X_WIDTH(A_WIDTH),
        .Y_WIDTH(DIGIT_WIDTH)
    ) u_array (
        .x(a_q),
        .y(cur_digit),
        .p(pp)
    );

    assign pp_ext   = P_W'(pp);
    assign shamt    = 32'(k) * 32'(DIGIT_WIDTH);
    assign acc_next = acc + (pp_ext << shamt);

    // Any nonzero digit above the one being consumed keeps the op running.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (j > int'(k) && b_q[j*DIGIT_WIDTH +: DIGIT_WIDTH] != '0) begin
                upper_nz = 1'b1;
            end
        end
    end

    assign last_digit = (k == K_W'(N - 1));
    assign run_exit   = last_digit || (EARLY_EXIT && !upper_nz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            k     <= '0;
            acc   <= '0;
        end else if (clear) begin
            state <= IDLE;
            k     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        k     <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    k   <= k + K_W'(1);
                    if (run_exit) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign prod      = acc;

endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Bench for digit_serial_mult_ctrl: instance 0 fixed latency, instance 1 early exit.
module tb_digit_serial_mult_ctrl;

    logic         clk;
    logic         rst_n;
    logic [1:0]   clear;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   out_ready;
    logic [1:0]   busy;
    logic [63:0]  a_s    [2];
    logic [63:0]  b_s    [2];
    logic [127:0] prod_s [2];

    int checks;
    int failures;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        digit_serial_mult_ctrl #(
            .A_WIDTH(64),
            .B_WIDTH(64),
            .DIGIT_WIDTH(8),
            .EARLY_EXIT(g == 1)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .clear(clear[g]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .a(a_s[g]),
            .b(b_s[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .prod(prod_s[g]),
            .busy(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_prod(input logic [63:0] av, input logic [63:0] bv);
        logic [127:0] x;
        logic [127:0] y;
        x = {64'd0, av};
        y = {64'd0, bv};
        return x * y;
    endfunction

    // Latency from the operand value alone: N, or 1 + most significant nonzero digit.
    function automatic int model_lat(input int idx, input logic [63:0] bv);
        int hi;
        if (idx == 0) return 8;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (((bv >> (8 * i)) & 64'hFF) != 64'd0) hi = i;
        end
        return hi + 1;
    endfunction

    // Starts and ends just after a falling edge.
    task automatic run_op(input int idx, input logic [63:0] av, input logic [63:0] bv,
                          input int in_gap, input int out_gap);
        int lat;
        logic [127:0] exp_p;
        exp_p = model_prod(av, bv);
        repeat (in_gap) @(negedge clk);
        check_val("in_ready_idle", in_ready[idx], 1'b1);
        in_valid[idx] = 1'b1;
        a_s[idx] = av;
        b_s[idx] = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        lat = 0;
        while (!out_valid[idx] && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val("latency", lat, model_lat(idx, bv));
        check_val("prod", prod_s[idx], exp_p);
        if (out_gap > 0) begin
            repeat (out_gap) @(negedge clk);
            check_val("bp_out_valid", out_valid[idx], 1'b1);
            check_val("bp_prod", prod_s[idx], exp_p);
        end
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        check_val("post_hs_out_valid", out_valid[idx], 1'b0);
        check_val("post_hs_in_ready", in_ready[idx], 1'b1);
    endtask

    initial begin
        logic [63:0]  av;
        logic [63:0]  bv;
        logic [127:0] p2;
        logic         saw_valid;
        int           lat;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        clear = '0;
        in_valid = '0;
        out_ready = '0;
        for (int i = 0; i < 2; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            check_val("rst_in_ready", in_ready[i], 1'b1);
            check_val("rst_out_valid", out_valid[i], 1'b0);
            check_val("rst_busy", busy[i], 1'b0);
            check_val("rst_prod", prod_s[i], 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_op(1, 64'd3, 64'd5, 0, 0);
        run_op(1, 64'h1234, 64'h0100, 0, 0);
        run_op(1, 64'h1234, 64'd0, 0, 0);
        run_op(0, 64'd3, 64'd5, 0, 0);

        // Backpressure with stray in_valid pulses while DONE.
        in_valid[1] = 1'b1;
        a_s[1] = 64'hDEAD_BEEF;
        b_s[1] = 64'h0000_0000_0001_0203;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        lat = 0;
        while (!out_valid[1] && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val("bp_latency", lat, 3);
        for (int c = 0; c < 5; c++) begin
            in_valid[1] = c[0];
            a_s[1] = 64'd1;
            b_s[1] = 64'd1;
            @(negedge clk);
            check_val("bp_hold_valid", out_valid[1], 1'b1);
            check_val("bp_hold_ready", in_ready[1], 1'b0);
            check_val("bp_hold_prod", prod_s[1], model_prod(64'hDEAD_BEEF, 64'h0000_0000_0001_0203));
        end
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        @(negedge clk);
        out_ready[1] = 1'b0;
        check_val("bp_release", out_valid[1], 1'b0);
        @(negedge clk);
        check_val("bp_no_accept", busy[1], 1'b0);

        // Abort part-way through RUN, after three digits.
        in_valid[1] = 1'b1;
        a_s[1] = 64'h0123_4567_89AB_CDEF;
        b_s[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        clear[1] = 1'b1;
        @(negedge clk);
        clear[1] = 1'b0;
        check_val("clr_busy", busy[1], 1'b0);
        check_val("clr_out_valid", out_valid[1], 1'b0);
        check_val("clr_prod", prod_s[1], 128'd0);
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[1]) saw_valid = 1'b1;
        end
        check_val("clr_no_out", saw_valid, 1'b0);
        run_op(1, 64'd7, 64'd9, 0, 0);

        // A clear in IDLE wins over in_valid.
        clear[0] = 1'b1;
        in_valid[0] = 1'b1;
        a_s[0] = 64'd5;
        b_s[0] = 64'd5;
        @(negedge clk);
        clear[0] = 1'b0;
        in_valid[0] = 1'b0;
        check_val("clr_idle_busy", busy[0], 1'b0);

        // Asynchronous reset in the middle of RUN.
        in_valid = 2'b11;
        a_s[0] = 64'hFFFF_0000_FFFF_0000;
        b_s[0] = 64'h1111_2222_3333_4444;
        a_s[1] = 64'hFFFF_0000_FFFF_0000;
        b_s[1] = 64'h1111_2222_3333_4444;
        @(posedge clk);
        @(negedge clk);
        in_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("arst_out_valid", out_valid[i], 1'b0);
            check_val("arst_prod", prod_s[i], 128'd0);
            check_val("arst_in_ready", in_ready[i], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        p2 = 128'd1 << 64;
        check_val("model_2p64", model_prod(64'h8000_0000_0000_0000, 64'd2), p2);
        run_op(1, 64'h8000_0000_0000_0000, 64'd2, 0, 0);
        run_op(0, 64'h8000_0000_0000_0000, 64'd2, 0, 0);

        // Random operands; b often truncated to exercise early exit.
        for (int i = 0; i < 3000; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) av = 64'hFFFF_FFFF_FFFF_FFFF;
            bv = bv >> (8 * $urandom_range(0, 8));
            if ($urandom_range(0, 5) == 0) bv = bv & ~(64'hFF << (8 * $urandom_range(0, 7)));
            run_op(i % 2, av, bv, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
